me_iddmm_mod_exp: RTL and testbench

- Word-serial modular exponentiator: computes result = X^Y mod M on K*N-bit operands.
- Uses an iterative digit-decomposed Montgomery multiplier (IDDMM) internally.
- Serves as the exponentiation core of the Paillier/RSA datapath.
- Operands stream in and the result streams out as N words of K bits, least-significant word first. Modulus constants are fixed per instance via parameters.

---
 rtl/me_iddmm_mod_exp.sv | 389 ++++++++++++++++++++++++++++++++++++++
 tb/tb_me_iddmm_mod_exp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/me_iddmm_mod_exp.sv
// Word-serial modular exponentiator: result = X^Y mod MOD on K*N-bit operands.
// Uses left-to-right square-and-multiply over every exponent bit. Each step is
// a Montgomery product from a word-serial IDDMM engine. Operands arrive and
// the result leaves as N words of K bits, least-significant word first.
//
// Handshake: a word is taken from me_x (me_y) on every rising edge where
// me_x_valid (me_y_valid) is high while the block is loading. The block takes
// at most N words per operand. me_result is meaningful only while me_valid is
// high, and stays at zero otherwise. There is no back-pressure.
//
// The default constants are a self-consistent generic set: MOD = 2^(K*N)-1,
// M_PRIME = 1, RR = 1. Instantiate the block with the project modulus and its
// matching constants.
module me_iddmm_mod_exp #(
    parameter int               K       = 128,
    parameter int               N       = 32,
    parameter logic [K*N-1:0]   MOD     = {(K*N){1'b1}},
    parameter logic [K-1:0]     M_PRIME = K'(1),
    parameter logic [K*N-1:0]   RR      = (K*N)'(1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         me_start,
    input  logic [K-1:0] me_x,
    input  logic         me_x_valid,
    input  logic [K-1:0] me_y,
    input  logic         me_y_valid,
    output logic [K-1:0] me_result,
    output logic         me_valid
);

    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int BW = (K > 1) ? $clog2(K) : 1;
    localparam int TW = 2 * K + 2;

    localparam logic [JW-1:0] J_LAST = JW'(N - 1);
    localparam logic [CW-1:0] C_FULL = CW'(N);
    localparam logic [BW-1:0] B_LAST = BW'(K - 1);
    localparam logic [K-1:0]  ONE_W  = K'(1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_PRE, ST_EXP, ST_POST, ST_OUT
    } state_t;

    typedef enum logic [2:0] {
        MM_IDLE, MM_Q, MM_INNER, MM_CMP, MM_SUB
    } mm_state_t;

    typedef enum logic [1:0] {A_X, A_ONE, A_ACC} asel_t;
    typedef enum logic [1:0] {B_RR, B_ACC, B_XM, B_ONE} bsel_t;
    typedef enum logic {D_XM, D_ACC} dsel_t;

    // Word views of the per-instance constants
    logic [K-1:0] mod_w [N];
    logic [K-1:0] rr_w  [N];

    for (genvar g = 0; g < N; g++) begin : g_const
        assign mod_w[g] = MOD[g*K +: K];
        assign rr_w[g]  = RR[g*K +: K];
    end

    // Operand and working storage
    logic [K-1:0] x_q   [N];
    logic [K-1:0] y_q   [N];
    logic [K-1:0] xm_q  [N];
    logic [K-1:0] acc_q [N];
    logic [K-1:0] s_q   [N];

    // Top-level sequencer state
    state_t        state_q;
    logic [CW-1:0] xcnt_q;
    logic [CW-1:0] ycnt_q;
    logic [JW-1:0] ew_q;
    logic [BW-1:0] eb_q;
    logic          step_q;
    logic          launched_q;
    logic          mm_go_q;
    asel_t         a_sel_q;
    bsel_t         b_sel_q;
    dsel_t         dst_q;
    logic [JW-1:0] oc_q;
    logic          me_valid_q;
    logic [K-1:0]  me_result_q;

    // Montgomery engine state
    mm_state_t     mm_state_q;
    logic [JW-1:0] i_q;
    logic [JW-1:0] j_q;
    logic [K-1:0]  q_q;
    logic [K+1:0]  carry_q;
    logic          s_top_q;
    logic          ge_q;
    logic          dec_q;
    logic          borrow_q;
    logic          mm_done_q;

    // Datapath nets
    logic          x_we;
    logic          y_we;
    logic          y_bit;
    logic [K-1:0]  a_word;
    logic [K-1:0]  b_word;
    logic [2*K-1:0] mul1;
    logic [K-1:0]  u_word;
    logic [K-1:0]  mul2_a;
    logic [K-1:0]  mul2_b;
    logic [2*K-1:0] mul2;
    logic [TW-1:0] t_sum;
    logic [K+1:0]  t_carry;
    logic [K:0]    t_top;
    logic [K:0]    diff;
    logic [K-1:0]  sub_word;
    logic          cmp_ge;
    logic          cmp_dec;

    assign x_we  = (state_q == ST_LOAD) && me_x_valid && (xcnt_q != C_FULL);
    assign y_we  = (state_q == ST_LOAD) && me_y_valid && (ycnt_q != C_FULL);
    assign y_bit = y_q[ew_q][eb_q];

    assign me_valid  = me_valid_q;
    assign me_result = me_result_q;

    // Sequencer: load, precompute, exponent loop, postcompute, stream out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            xcnt_q      <= '0;
            ycnt_q      <= '0;
            ew_q        <= '0;
            eb_q        <= '0;
            step_q      <= 1'b0;
            launched_q  <= 1'b0;
            mm_go_q     <= 1'b0;
            a_sel_q     <= A_X;
            b_sel_q     <= B_RR;
            dst_q       <= D_XM;
            oc_q        <= '0;
            me_valid_q  <= 1'b0;
            me_result_q <= '0;
        end else begin
            mm_go_q     <= 1'b0;
            me_valid_q  <= 1'b0;
            me_result_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (me_start) begin
                        state_q <= ST_LOAD;
                        xcnt_q  <= '0;
                        ycnt_q  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (x_we) xcnt_q <= xcnt_q + 1'b1;
                    if (y_we) ycnt_q <= ycnt_q + 1'b1;
                    if ((xcnt_q == C_FULL) && (ycnt_q == C_FULL)) begin
                        state_q    <= ST_PRE;
                        step_q     <= 1'b0;
                        launched_q <= 1'b0;
                    end
                end
                ST_PRE: begin
                    // step 0: xm = MM(X, RR); step 1: acc = MM(1, RR)
                    if (!launched_q) begin
                        launched_q <= 1'b1;
                        mm_go_q    <= 1'b1;
                        a_sel_q    <= step_q ? A_ONE : A_X;
                        b_sel_q    <= B_RR;
                        dst_q      <= step_q ? D_ACC : D_XM;
                    end else if (mm_done_q) begin
                        launched_q <= 1'b0;
                        if (step_q) begin
                            state_q <= ST_EXP;
                            step_q  <= 1'b0;
                            ew_q    <= J_LAST;
                            eb_q    <= B_LAST;
                        end else begin
                            step_q <= 1'b1;
                        end
                    end
                end
                ST_EXP: begin
                    // step 0 squares, step 1 multiplies by xm when the bit is set
                    if (!launched_q) begin
                        launched_q <= 1'b1;
                        mm_go_q    <= 1'b1;
                        a_sel_q    <= A_ACC;
                        b_sel_q    <= step_q ? B_XM : B_ACC;
                        dst_q      <= D_ACC;
                    end else if (mm_done_q) begin
                        launched_q <= 1'b0;
                        if (!step_q && y_bit) begin
                            step_q <= 1'b1;
                        end else begin
                            step_q <= 1'b0;
                            if (eb_q == '0) begin
                                if (ew_q == '0) begin
                                    state_q <= ST_POST;
                                end else begin
                                    ew_q <= ew_q - 1'b1;
                                    eb_q <= B_LAST;
                                end
                            end else begin
                                eb_q <= eb_q - 1'b1;
                            end
                        end
                    end
                end
                ST_POST: begin
                    // Leave Montgomery form: acc = MM(acc, 1)
                    if (!launched_q) begin
                        launched_q <= 1'b1;
                        mm_go_q    <= 1'b1;
                        a_sel_q    <= A_ACC;
                        b_sel_q    <= B_ONE;
                        dst_q      <= D_ACC;
                    end else if (mm_done_q) begin
                        launched_q <= 1'b0;
                        state_q    <= ST_OUT;
                        oc_q       <= '0;
                    end
                end
                ST_OUT: begin
                    me_valid_q  <= 1'b1;
                    me_result_q <= acc_q[oc_q];
                    if (oc_q == J_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        oc_q <= oc_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Operand capture while loading; the source may change afterwards
    always_ff @(posedge clk) begin
        if (x_we) x_q[xcnt_q[JW-1:0]] <= me_x;
        if (y_we) y_q[ycnt_q[JW-1:0]] <= me_y;
    end

    // Operand word selection and the shared multiplier pair
    always_comb begin
        a_word = '0;
        case (a_sel_q)
            A_X:     a_word = x_q[i_q];
            A_ONE:   a_word = (i_q == '0) ? ONE_W : '0;
            A_ACC:   a_word = acc_q[i_q];
            default: a_word = '0;
        endcase

        b_word = '0;
        case (b_sel_q)
            B_RR:    b_word = rr_w[j_q];
            B_ACC:   b_word = acc_q[j_q];
            B_XM:    b_word = xm_q[j_q];
            B_ONE:   b_word = (j_q == '0) ? ONE_W : '0;
            default: b_word = '0;
        endcase

        mul1 = (2*K)'(a_word) * (2*K)'(b_word);
        // In the q cycle the second multiplier forms (S0 + a_i*B0) * M_PRIME
        u_word = s_q[0] + mul1[K-1:0];
        mul2_a = (mm_state_q == MM_Q) ? u_word : q_q;
        mul2_b = (mm_state_q == MM_Q) ? M_PRIME : mod_w[j_q];
        mul2   = (2*K)'(mul2_a) * (2*K)'(mul2_b);

        t_sum   = TW'(s_q[j_q]) + TW'(mul1) + TW'(mul2) + TW'(carry_q);
        t_carry = t_sum[TW-1:K];
        t_top   = (K+1)'(t_carry) + (K+1)'(s_top_q);

        diff     = {1'b0, s_q[j_q]} - {1'b0, mod_w[j_q]} - (K+1)'(borrow_q);
        sub_word = ge_q ? diff[K-1:0] : s_q[j_q];
    end

    // MSW-first comparison of S against MOD; an equal word leaves the decision open
    always_comb begin
        cmp_ge  = ge_q;
        cmp_dec = dec_q;
        if (!dec_q) begin
            if (s_top_q) begin
                cmp_ge  = 1'b1;
                cmp_dec = 1'b1;
            end else if (s_q[j_q] != mod_w[j_q]) begin
                cmp_ge  = (s_q[j_q] > mod_w[j_q]);
                cmp_dec = 1'b1;
            end else begin
                cmp_ge = 1'b1;
            end
        end
    end

    // Montgomery engine control: q cycle, N inner cycles per outer word, compare, subtract
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_state_q <= MM_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            q_q        <= '0;
            carry_q    <= '0;
            s_top_q    <= 1'b0;
            ge_q       <= 1'b0;
            dec_q      <= 1'b0;
            borrow_q   <= 1'b0;
            mm_done_q  <= 1'b0;
        end else begin
            mm_done_q <= 1'b0;
            case (mm_state_q)
                MM_IDLE: begin
                    if (mm_go_q) begin
                        mm_state_q <= MM_Q;
                        i_q        <= '0;
                        j_q        <= '0;
                        s_top_q    <= 1'b0;
                    end
                end
                MM_Q: begin
                    q_q        <= mul2[K-1:0];
                    carry_q    <= '0;
                    j_q        <= '0;
                    mm_state_q <= MM_INNER;
                end
                MM_INNER: begin
                    carry_q <= t_carry;
                    if (j_q == J_LAST) begin
                        s_top_q <= t_top[K];
                        if (i_q == J_LAST) begin
                            mm_state_q <= MM_CMP;
                            j_q        <= J_LAST;
                            ge_q       <= 1'b0;
                            dec_q      <= 1'b0;
                        end else begin
                            i_q        <= i_q + 1'b1;
                            j_q        <= '0;
                            mm_state_q <= MM_Q;
                        end
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                MM_CMP: begin
                    ge_q  <= cmp_ge;
                    dec_q <= cmp_dec;
                    if (j_q == '0) begin
                        mm_state_q <= MM_SUB;
                        borrow_q   <= 1'b0;
                    end else begin
                        j_q <= j_q - 1'b1;
                    end
                end
                MM_SUB: begin
                    borrow_q <= diff[K];
                    if (j_q == J_LAST) begin
                        mm_state_q <= MM_IDLE;
                        mm_done_q  <= 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                default: mm_state_q <= MM_IDLE;
            endcase
        end
    end

    // Engine storage: clear S, accumulate shifted partial sums, write reduced result
    always_ff @(posedge clk) begin
        case (mm_state_q)
            MM_IDLE: begin
                if (mm_go_q) begin
                    for (int w = 0; w < N; w++) begin
                        s_q[w] <= '0;
                    end
                end
            end
            MM_INNER: begin
                // Word 0 of each sum is zero by choice of q and is shifted out
                if (j_q != '0) s_q[j_q - 1'b1] <= t_sum[K-1:0];
                if (j_q == J_LAST) s_q[J_LAST] <= t_top[K-1:0];
            end
            MM_SUB: begin
                if (dst_q == D_ACC) acc_q[j_q] <= sub_word;
                else                xm_q[j_q]  <= sub_word;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_me_iddmm_mod_exp.sv
// Directed bench for me_iddmm_mod_exp in the small configuration
// (K=8, N=2, MOD=0xC3A5). Expected results are hand-computed, plus a
// pow(x,y,MOD) reference model for a few extra operand pairs.
module tb_me_iddmm_mod_exp;

    localparam int K = 8;
    localparam int N = 2;
    localparam int W = K * N;
    localparam logic [W-1:0] MOD_C   = 16'hC3A5;
    localparam logic [K-1:0] MPRIME_C = 8'hD3;   // -MOD^-1 mod 256 (MOD^-1 = 0x2D)
    localparam logic [W-1:0] RR_C    = 16'h6E83; // 2^32 mod MOD = 28291
    localparam int TIMEOUT = 5000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         me_start = 1'b0;
    logic [K-1:0] me_x = '0;
    logic         me_x_valid = 1'b0;
    logic [K-1:0] me_y = '0;
    logic         me_y_valid = 1'b0;
    logic [K-1:0] me_result;
    logic         me_valid;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           off;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [9];

    me_iddmm_mod_exp #(
        .K(K), .N(N), .MOD(MOD_C), .M_PRIME(MPRIME_C), .RR(RR_C)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .me_start(me_start),
        .me_x(me_x),
        .me_x_valid(me_x_valid),
        .me_y(me_y),
        .me_y_valid(me_y_valid),
        .me_result(me_result),
        .me_valid(me_valid)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_pow(input logic [W-1:0] x, input logic [W-1:0] y);
        longint unsigned r;
        longint unsigned b;
        longint unsigned m;
        m = longint'(MOD_C);
        b = longint'(x) % m;
        r = 1;
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % m;
            if (y[i]) r = (r * b) % m;
        end
        return W'(r);
    endfunction

    // Driver: start pulse, then N+1 beats per operand (trailing zero word),
    // with the Y beats delayed by 'off' cycles relative to X
    task automatic send_op(input logic [W-1:0] x, input logic [W-1:0] y, input int off);
        me_start = 1'b1;
        tick();
        me_start = 1'b0;
        for (int c = 0; c < N + 1 + off; c++) begin
            me_x_valid = (c <= N);
            me_x       = (c < N) ? x[c*K +: K] : '0;
            me_y_valid = (c >= off) && (c - off <= N);
            me_y       = ((c >= off) && (c - off < N)) ? y[(c-off)*K +: K] : '0;
            tick();
        end
        me_x_valid = 1'b0;
        me_y_valid = 1'b0;
        me_x       = '0;
        me_y       = '0;
    endtask

    // Scoreboard side: wait for the burst, reassemble LSW first, check framing
    task automatic collect(input string name, input logic [W-1:0] exp);
        int waited;
        int cnt;
        logic [W-1:0] got;
        waited = 0;
        cnt = 0;
        got = '0;
        while (!me_valid && waited < TIMEOUT) begin
            tick();
            waited++;
        end
        if (!me_valid) begin
            chk({name, "_timeout"}, W'(me_valid), W'(1));
            return;
        end
        while (me_valid && cnt <= N) begin
            if (cnt < N) got[cnt*K +: K] = me_result;
            cnt++;
            tick();
        end
        chk({name, "_result"}, got, exp);
        chk({name, "_beats"}, W'(cnt), W'(N));
        chk({name, "_valid_after"}, W'(me_valid), '0);
        chk({name, "_result_after"}, W'(me_result), '0);
    endtask

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        bit saw;

        vecs[0] = '{x: 16'h0002, y: 16'h000A, off: 0, exp: 16'h0400};
        vecs[1] = '{x: 16'h1234, y: 16'h0000, off: 0, exp: 16'h0001};
        vecs[2] = '{x: 16'hFFFF, y: 16'h0001, off: 0, exp: 16'h3C5A};
        vecs[3] = '{x: 16'h0000, y: 16'h0005, off: 0, exp: 16'h0000};
        vecs[4] = '{x: 16'h0003, y: 16'h0002, off: 0, exp: 16'h0009};
        vecs[5] = '{x: 16'h0100, y: 16'h0002, off: 0, exp: 16'h3C5B};
        vecs[6] = '{x: 16'hC3A5, y: 16'h0003, off: 0, exp: 16'h0000};
        vecs[7] = '{x: 16'hC3A6, y: 16'h0007, off: 0, exp: 16'h0001};
        vecs[8] = '{x: 16'h0002, y: 16'h000A, off: 3, exp: 16'h0400};

        // Reset
        tick();
        chk("reset_valid", W'(me_valid), '0);
        chk("reset_result", W'(me_result), '0);
        rst_n = 1'b1;
        tick();

        // Table of directed vectors
        for (int v = 0; v < 9; v++) begin
            send_op(vecs[v].x, vecs[v].y, vecs[v].off);
            collect($sformatf("vec%0d", v), vecs[v].exp);
        end

        // A square that needs the final subtraction: 0xFFFF^2 mod MOD = 0xB973
        send_op(16'hFFFF, 16'h0002, 1);
        collect("sq_ffff", 16'hB973);

        // Valid beats in IDLE must not be captured
        me_x_valid = 1'b1;
        me_y_valid = 1'b1;
        me_x = 8'hFF;
        me_y = 8'hFF;
        repeat (3) tick();
        me_x_valid = 1'b0;
        me_y_valid = 1'b0;
        me_x = '0;
        me_y = '0;
        send_op(16'h0003, 16'h0002, 0);
        collect("idle_beats", 16'h0009);

        // me_start and beats during the exponent loop are ignored
        send_op(16'h0002, 16'h000A, 0);
        repeat (150) tick();
        me_start = 1'b1;
        me_x_valid = 1'b1;
        me_y_valid = 1'b1;
        me_x = 8'h55;
        me_y = 8'h77;
        tick();
        me_start = 1'b0;
        repeat (2) tick();
        me_x_valid = 1'b0;
        me_y_valid = 1'b0;
        me_x = '0;
        me_y = '0;
        collect("start_in_exp", 16'h0400);

        // Reset mid-exponentiation aborts without output
        send_op(16'h1234, 16'hFFFF, 0);
        repeat (200) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_valid", W'(me_valid), '0);
        chk("abort_result", W'(me_result), '0);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (me_valid) saw = 1'b1;
        end
        chk("abort_no_output", W'(saw), '0);
        send_op(16'h0100, 16'h0002, 2);
        collect("after_abort", 16'h3C5B);

        // Extra operand pairs against the reference model
        for (int r = 0; r < 4; r++) begin
            rx = W'($urandom_range(0, 16'hFFFF));
            ry = W'($urandom_range(0, 16'hFFFF));
            send_op(rx, ry, r % 3);
            collect($sformatf("rand%0d", r), ref_pow(rx, ry));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
